// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - classifies debounced presses into click, double click, long press and repeat pulses
module key_event_decoder #(
  parameter int                 CNT_W        = 24,
  parameter logic [CNT_W-1:0]   LONG_TICKS   = 24'd12_000_000,
  parameter logic [CNT_W-1:0]   REPEAT_TICKS = 24'd3_000_000,
  parameter logic [CNT_W-1:0]   DCLICK_TICKS = 24'd6_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       press_pulse,
  input  logic       key_level,
  output logic       click,
  output logic       double_click,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic       busy,
  output logic [1:0] last_event,
  output logic [7:0] event_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HELD     = 3'd1,
    REPEAT   = 3'd2,
    WAIT_GAP = 3'd3,
    HELD2    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LONG_LAST   = LONG_TICKS - CNT_ONE;
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_TICKS - CNT_ONE;
  localparam logic [CNT_W-1:0] DCLICK_LAST = DCLICK_TICKS - CNT_ONE;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      busy         <= 1'b0;
      last_event   <= 2'd0;
      event_count  <= 8'd0;
    end else begin
      click        <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (press_pulse) begin
            state <= HELD;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        HELD: begin
          if (!key_level) begin
            state <= WAIT_GAP;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            long_press  <= 1'b1;
            last_event  <= 2'd3;
            event_count <= event_count + 8'd1;
            cnt         <= '0;
            state       <= REPEAT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        // Releasing after a long press is silent: the long event already fired.
        REPEAT: begin
          if (!key_level) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == REPEAT_LAST) begin
            repeat_pulse <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        // A press on the timeout edge still wins and becomes a double click.
        WAIT_GAP: begin
          if (press_pulse) begin
            state <= HELD2;
            cnt   <= '0;
          end else if (cnt == DCLICK_LAST) begin
            click       <= 1'b1;
            last_event  <= 2'd1;
            event_count <= event_count + 8'd1;
            cnt         <= '0;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD2: begin
          if (!key_level) begin
            double_click <= 1'b1;
            last_event   <= 2'd2;
            event_count  <= event_count + 8'd1;
            state        <= IDLE;
            busy         <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - scoreboard bench for key_event_decoder
module tb_key_event_decoder;

  logic       clk;
  logic       rst_n;
  logic       press_pulse;
  logic       key_level;
  logic       click;
  logic       double_click;
  logic       long_press;
  logic       repeat_pulse;
  logic       busy;
  logic [1:0] last_event;
  logic [7:0] event_count;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc;
  int   n_vec;
  int   n_miss;
  int   exp_count;
  int   exp_last;

  key_event_decoder #(
    .CNT_W       (24),
    .LONG_TICKS  (24'd20),
    .REPEAT_TICKS(24'd8),
    .DCLICK_TICKS(24'd10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .press_pulse (press_pulse),
    .key_level   (key_level),
    .click       (click),
    .double_click(double_click),
    .long_press  (long_press),
    .repeat_pulse(repeat_pulse),
    .busy        (busy),
    .last_event  (last_event),
    .event_count (event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kinds: 1 click, 2 double, 3 long, 4 repeat
  always @(negedge clk) begin
    if (rst_n && (click || double_click || long_press || repeat_pulse)) begin
      int   kind;
      ev_t  e;
      kind = click ? 1 : double_click ? 2 : long_press ? 3 : 4;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected none", kind, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind !== kind || e.cyc !== cyc) begin
          n_miss++;
          $display("FAIL pulse_event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                   kind, cyc, e.kind, e.cyc);
        end
      end
      n_vec++;
      if (busy !== (kind >= 3)) begin
        n_miss++;
        $display("FAIL busy_at_pulse: got %0b for kind %0d, expected %0b", busy, kind, kind >= 3);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_press(output int e);
    press_pulse = 1'b1;
    key_level   = 1'b1;
    tick();
    e = cyc;
    press_pulse = 1'b0;
  endtask

  task automatic do_release(output int r);
    key_level = 1'b0;
    tick();
    r = cyc;
  endtask

  task automatic push_ev(input int kind, input int at);
    exp_q.push_back('{kind, at});
  endtask

  task automatic wait_drain(input string name, input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL %s_drain: %0d events pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_status(input string name);
    n_vec++;
    if (last_event !== exp_last[1:0]) begin
      n_miss++;
      $display("FAIL %s_last_event: got %0d, expected %0d", name, last_event, exp_last);
    end
    n_vec++;
    if (event_count !== exp_count[7:0]) begin
      n_miss++;
      $display("FAIL %s_event_count: got %0d, expected %0d", name, event_count, exp_count);
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_miss++;
      $display("FAIL %s_busy_idle: got %0b, expected 0", name, busy);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    press_pulse = 1'b0;
    key_level = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    exp_count = 0;
    exp_last  = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if ({click, double_click, long_press, repeat_pulse} !== 4'b0) begin
      n_miss++;
      $display("FAIL reset_pulses: got %b, expected 0000",
               {click, double_click, long_press, repeat_pulse});
    end
    check_status("reset");
  endtask

  task automatic test_single_click();
    int e, r;
    do_press(e);
    repeat (4) tick();
    do_release(r);
    push_ev(1, r + 10);
    exp_count++;
    exp_last = 1;
    tick();
    n_vec++;
    if (busy !== 1'b1) begin
      n_miss++;
      $display("FAIL click_busy_gap: got %0b, expected 1", busy);
    end
    wait_drain("click", 30);
    tick();
    check_status("click");
  endtask

  task automatic test_reset_mid_held();
    int e;
    do_press(e);
    repeat (3) tick();
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, click, double_click, long_press, repeat_pulse} !== 5'b0) begin
      n_miss++;
      $display("FAIL async_reset_outputs: got %b, expected 00000",
               {busy, click, double_click, long_press, repeat_pulse});
    end
    exp_count = 0;
    exp_last  = 0;
    n_vec++;
    if (event_count !== 8'd0 || last_event !== 2'd0) begin
      n_miss++;
      $display("FAIL async_reset_status: got count %0d last %0d, expected 0 0",
               event_count, last_event);
    end
    key_level = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check_status("reset_abort");
  endtask

  task automatic test_double_click();
    int e, r;
    do_press(e);
    repeat (2) tick();
    do_release(r);
    repeat (3) tick();
    do_press(e);
    repeat (2) tick();
    do_release(r);
    push_ev(2, r);
    exp_count++;
    exp_last = 2;
    wait_drain("double", 5);
    repeat (15) tick();
    check_status("double");
  endtask

  task automatic test_long_repeat();
    int e, r;
    do_press(e);
    push_ev(3, e + 20);
    push_ev(4, e + 28);
    push_ev(4, e + 36);
    push_ev(4, e + 44);
    exp_count++;
    exp_last = 3;
    repeat (49) tick();
    do_release(r);
    wait_drain("long", 5);
    repeat (20) tick();
    check_status("long");
  endtask

  task automatic test_race();
    int e, r;
    do_press(e);
    do_release(r);
    repeat (9) tick();
    do_press(e);
    tick();
    do_release(r);
    push_ev(2, r);
    exp_count++;
    exp_last = 2;
    wait_drain("race", 5);
    repeat (15) tick();
    check_status("race");
  endtask

  task automatic test_wrap();
    int e, r;
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      do_press(e);
      do_release(r);
      push_ev(1, r + 10);
      exp_count = (exp_count + 1) % 256;
      exp_last = 1;
      repeat (11) tick();
    end
    wait_drain("wrap", 5);
    n_vec++;
    if (event_count !== 8'd0) begin
      n_miss++;
      $display("FAIL wrap_zero: got %0d, expected 0", event_count);
    end
    check_status("wrap");
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    exp_count = 0;
    exp_last = 0;
    rst_n = 1'b0;
    press_pulse = 1'b0;
    key_level = 1'b0;
    test_reset();
    test_single_click();
    test_reset_mid_held();
    test_double_click();
    test_long_repeat();
    test_race();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
